// File: rtl/stream_pkg.sv
// Shared stream-path types and default widths for the arbiter, skid stage and stream generators.
package stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int STREAM_DATA_W = 32;
  localparam int STREAM_CNT_W  = 16;

endpackage

// File: rtl/axis_skid.sv
// Two-entry AXI-Stream register stage: full throughput, with s_tready taken straight from a flop.
module axis_skid #(
  parameter  int DATA_W = 32,
  localparam int KEEP_W = DATA_W / 8
) (
  input  logic              axi_aclk,
  input  logic              axi_reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready
);

  logic              sk_valid;
  logic [DATA_W-1:0] sk_tdata;
  logic [KEEP_W-1:0] sk_tkeep;
  logic              sk_tlast;
  logic              in_fire;

  // Ready depends only on skid occupancy, so the downstream ready never reaches upstream combinationally.
  assign s_tready = ~sk_valid;
  assign in_fire  = s_tvalid & ~sk_valid;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      sk_valid <= 1'b0;
      sk_tdata <= '0;
      sk_tkeep <= '0;
      sk_tlast <= 1'b0;
    end else if (!m_tvalid || m_tready) begin
      if (sk_valid) begin
        m_tvalid <= 1'b1;
        m_tdata  <= sk_tdata;
        m_tkeep  <= sk_tkeep;
        m_tlast  <= sk_tlast;
        sk_valid <= 1'b0;
      end else begin
        m_tvalid <= in_fire;
        if (in_fire) begin
          m_tdata <= s_tdata;
          m_tkeep <= s_tkeep;
          m_tlast <= s_tlast;
        end
      end
    end else if (in_fire) begin
      // Main register is stalled: park the beat accepted this cycle.
      sk_valid <= 1'b1;
      sk_tdata <= s_tdata;
      sk_tkeep <= s_tkeep;
      sk_tlast <= s_tlast;
    end
  end

endmodule

// File: rtl/stream_arb.sv
// Frame-level round-robin merge of NUM_IN AXI-Stream sources onto one registered output.
module stream_arb
  import stream_pkg::*;
#(
  parameter  int NUM_IN = 2,
  parameter  int DATA_W = STREAM_DATA_W,
  parameter  int CNT_W  = STREAM_CNT_W,
  localparam int KEEP_W = DATA_W / 8,
  localparam int GW     = $clog2(NUM_IN)
) (
  input  logic                     axi_aclk,
  input  logic                     axi_reset,
  input  logic [NUM_IN*DATA_W-1:0] s_tdata,
  input  logic [NUM_IN*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_IN-1:0]        s_tlast,
  input  logic [NUM_IN-1:0]        s_tvalid,
  output logic [NUM_IN-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [KEEP_W-1:0]        m_tkeep,
  output logic                     m_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [GW-1:0]            grant,
  output logic                     busy,
  output logic [NUM_IN*CNT_W-1:0]  frame_cnt
);

  arb_state_t        state;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     win;
  logic              win_vld;
  int                idx;
  logic [DATA_W-1:0] sel_tdata;
  logic [KEEP_W-1:0] sel_tkeep;
  logic              sel_tlast;
  logic              sel_valid;
  logic              sk_ready;
  logic              xfer;
  logic              done;

  assign sel_tdata = s_tdata[int'(grant)*DATA_W +: DATA_W];
  assign sel_tkeep = s_tkeep[int'(grant)*KEEP_W +: KEEP_W];
  assign sel_tlast = s_tlast[grant];
  assign sel_valid = (state == LOCK) & s_tvalid[grant];
  assign xfer      = sel_valid & sk_ready;
  assign done      = xfer & sel_tlast;

  always_comb begin
    s_tready = '0;
    if (state == LOCK) s_tready[grant] = sk_ready;
  end

  // Search upward from the previous owner so every requester gets a turn.
  always_comb begin
    win     = last_grant;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = (int'(last_grant) + k) % NUM_IN;
      if (!win_vld && s_tvalid[idx]) begin
        win_vld = 1'b1;
        win     = GW'(idx);
      end
    end
  end

  // last_grant is kept apart from grant so input 0 wins first even though grant reads 0 in reset.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_IN - 1);
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          state      <= LOCK;
          grant      <= win;
          last_grant <= win;
          busy       <= 1'b1;
        end
        LOCK: if (done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge axi_aclk) begin
      if (axi_reset)                       cnt_q <= '0;
      else if (done && grant == GW'(i))    cnt_q <= cnt_q + 1'b1;
    end
    assign frame_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end

  axis_skid #(.DATA_W(DATA_W)) u_skid (
    .axi_aclk  (axi_aclk),
    .axi_reset (axi_reset),
    .s_tdata   (sel_tdata),
    .s_tkeep   (sel_tkeep),
    .s_tlast   (sel_tlast),
    .s_tvalid  (sel_valid),
    .s_tready  (sk_ready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready)
  );

endmodule

// File: doc/stream_arb.md
# stream_arb

Frame-level round-robin arbiter that merges NUM_IN AXI-Stream sources (stream generators, capture front-ends) into the single `stream_in` AXI-Stream port of the XDMA system block. A grant is held from the first accepted beat to the accepted `tlast` beat, so frames are never interleaved. A registered, full-throughput output stage isolates the DMA backpressure path. Per-input frame counters and the current grant are exported to status registers.

## Interface
- NUM_IN, 2, number of source ports (2..8)
- DATA_W, 32, tdata width in bits; tkeep width is DATA_W/8
- CNT_W, 16, width of each per-input frame counter
- axi_aclk  in  1  clock; all logic on the rising edge
- axi_reset  in  1  synchronous, active-high reset
- s_tdata  in  NUM_IN*DATA_W  source data; input i occupies bits [i*DATA_W +: DATA_W]
- s_tkeep  in  NUM_IN*DATA_W/8  source byte enables, packed the same way
- s_tlast  in  NUM_IN  source end-of-frame
- s_tvalid  in  NUM_IN  source valid
- s_tready  out  NUM_IN  source ready
- m_tdata  out  DATA_W  merged data to the DMA stream_in
- m_tkeep  out  DATA_W/8  merged byte enables
- m_tlast  out  1  merged end-of-frame
- m_tvalid  out  1  merged valid
- m_tready  in  1  DMA ready
- grant  out  $clog2(NUM_IN)  index of the input currently owning the output
- busy  out  1  high while a frame is locked (state LOCK)
- frame_cnt  out  NUM_IN*CNT_W  completed frames per input, packed the same way

## Operation
- States: IDLE, LOCK.
- IDLE: all `s_tready` low. If any `s_tvalid` is high, select the first requester found searching upward from (last grant + 1) mod NUM_IN, with wrap. Register it into `grant` and go to LOCK. If none is requesting, stay in IDLE.
- LOCK: `s_tready[grant]` = output stage can accept. All other `s_tready` stay low.
  - Beat transfer is `s_tvalid[grant] & s_tready[grant]`.
  - A transfer with `s_tlast` high increments `frame_cnt[grant]` (wraps modulo 2^CNT_W) and returns the FSM to IDLE.
- Last grant resets to NUM_IN-1, so input 0 wins the first arbitration after reset.
- `grant` holds its value in IDLE (last owner) until the next arbitration.
- A granted source that deasserts `tvalid` mid-frame keeps the lock; no timeout.
- Output stage is a 2-entry skid buffer:
  - Main register plus skid register.
  - `s_tready` path is registered as "skid empty".
  - Sustains 1 beat/cycle with `m_tready` held high.
  - Never drops or duplicates a beat under arbitrary `m_tready` toggling.
- tdata, tkeep and tlast pass unmodified.

## Timing
- Arbitration costs one cycle per frame: the cycle a request is seen in IDLE, `s_tready` is low. The first beat can transfer on the next cycle.
- Back-to-back frames therefore have exactly one idle input cycle between the `tlast` beat and the next first beat.
- Latency: a beat accepted on input at edge N appears on `m_t*` with `m_tvalid` high after edge N (1-cycle registered).
- `m_tvalid` may stay high across the IDLE bubble while the skid drains.
- `busy` rises on the edge that enters LOCK. It falls on the edge of the `tlast` transfer.
- Reset (any time, including mid-frame): at the first edge with `axi_reset` high, the following are all cleared to 0, and stay 0 while reset is held:
  - `m_tvalid`, `m_tlast`, `m_tdata`, `m_tkeep`, `s_tready`, `busy`, `grant`, `frame_cnt`
  - skid contents
- Partially transferred frames are discarded. The FSM is in IDLE on the first edge after reset deasserts.
- Simultaneous `tlast` transfer and new requests: the FSM goes to IDLE, and the next winner is computed from the just-finished grant.

## Structure
- Package `stream_pkg`:
  - typedef `arb_state_t` {IDLE, LOCK}
  - localparam defaults for DATA_W and CNT_W, shared with stream_gen configuration
- Sub-module `axis_skid` (DATA_W parameter, carries tdata/tkeep/tlast): the output register stage, reused elsewhere for DMA-side timing isolation.
- Round-robin search is a `for` loop in combinational logic inside stream_arb; no separate module.

## Test plan
- Single source: input 0 sends a 4-beat frame (tdata 0x10..0x13, tlast on 0x13), `m_tready` held high.
  - Output shows 0x10..0x13 on 4 consecutive cycles, 2 cycles after the first `s_tvalid`.
  - `frame_cnt[0]`=1, `busy` low afterwards.
- Contention, NUM_IN=2: both inputs continuously offer 3-beat frames from reset.
  - Output frame order is 0,1,0,1.
  - One bubble cycle between frames; no beats from different inputs inside one frame.
- Backpressure: 16-beat frame with `m_tready` driven by a pseudo-random pattern (50%).
  - All 16 beats arrive in order, none duplicated or lost.
  - `s_tready` is never high while the skid is full.
- Reset mid-frame: assert `axi_reset` for 1 cycle after beat 2 of 8.
  - All outputs are 0 on the next cycle.
  - The next frame from input 1 is granted normally; `frame_cnt` is restarted from 0.
- Counter wrap, CNT_W=4: 17 single-beat frames on input 1.
  - `frame_cnt[1]`=1.
  - `grant` stays 1 (no other requester).
